// File: rtl/edge_rate_meter_pkg.sv
// Shared types and defaults for the edge rate meter: FSM state encoding
// and the default gate length, count width and synchronizer depth.
package edge_rate_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_GATE = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam int DEF_GATE_CYCLES = 1000;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;

  function automatic logic is_busy(input state_t st);
    return (st == ST_ARM) || (st == ST_GATE);
  endfunction

endpackage

// File: rtl/edge_rate_meter_if.sv
// Measurement request/result bundle; the meter is the slave side,
// the requesting logic (and the measured signal source) the master side.
interface edge_rate_meter_if
  import edge_rate_meter_pkg::*;
  #(parameter int CNT_W = DEF_CNT_W);

  logic             wSigIn;
  logic             wStart;
  logic             wReady;
  logic             rBusy;
  logic             rValid;
  logic [CNT_W-1:0] rCount;
  logic             rOverflow;

  modport master (
    output wSigIn, wStart, wReady,
    input  rBusy, rValid, rCount, rOverflow
  );

  modport slave (
    input  wSigIn, wStart, wReady,
    output rBusy, rValid, rCount, rOverflow
  );

endinterface

// File: rtl/edge_rate_meter_sync_edge_detect.sv
// Synchronizes an asynchronous input and emits a one-cycle rising-edge pulse.
// prime suppresses the pulse for the cycle in which a measurement is armed.
module edge_rate_meter_sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  input  logic prime,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev;
  logic              synced;

  assign synced = sync_q[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], sig};
      prev   <= synced;
    end
  end

  // prev always tracks synced, so after the prime cycle the next comparison
  // is against the level seen while arming and a static input reads as no edge.
  assign rise = synced & ~prev & ~prime;

endmodule

// File: rtl/edge_rate_meter.sv
// Gated rising-edge counter: counts edges of an external signal over a
// fixed window and presents the result on a valid/ready output.
//
// state   | meaning
// IDLE    | waiting for wStart
// ARM     | one cycle: clear counters, prime edge detector, load gate timer
// GATE    | window open, counting edges, gate timer running down
// HOLD    | result valid, waiting for wReady
module edge_rate_meter
  import edge_rate_meter_pkg::*;
  #(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
  ) (
    input logic        wClk,
    input logic        wRst,
    edge_rate_meter_if.slave bus
  );

  localparam int GATE_W = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);

  state_t             state;
  logic [GATE_W-1:0]  gate_cnt;
  logic [CNT_W-1:0]   edge_cnt;
  logic [CNT_W-1:0]   edge_next;
  logic               sat_hit;
  logic               rise;

  edge_rate_meter_sync_edge_detect #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (wClk),
    .rst   (wRst),
    .sig   (bus.wSigIn),
    .prime (state == ST_ARM),
    .rise  (rise)
  );

  // The final gate cycle's edge must be included in the latched result.
  always_comb begin
    edge_next = edge_cnt;
    sat_hit   = 1'b0;
    if (rise) begin
      if (edge_cnt == '1) sat_hit = 1'b1;
      else                edge_next = edge_cnt + 1'b1;
    end
  end

  always_ff @(posedge wClk) begin
    if (wRst) begin
      state         <= ST_IDLE;
      gate_cnt      <= '0;
      edge_cnt      <= '0;
      bus.rBusy     <= 1'b0;
      bus.rValid    <= 1'b0;
      bus.rCount    <= '0;
      bus.rOverflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.wStart) begin
            state     <= ST_ARM;
            bus.rBusy <= is_busy(ST_ARM);
          end
        end
        ST_ARM: begin
          edge_cnt      <= '0;
          bus.rOverflow <= 1'b0;
          gate_cnt      <= GATE_LOAD;
          state         <= ST_GATE;
          bus.rBusy     <= is_busy(ST_GATE);
        end
        ST_GATE: begin
          edge_cnt <= edge_next;
          if (sat_hit) bus.rOverflow <= 1'b1;
          if (gate_cnt == '0) begin
            bus.rCount <= edge_next;
            bus.rValid <= 1'b1;
            bus.rBusy  <= is_busy(ST_HOLD);
            state      <= ST_HOLD;
          end else begin
            gate_cnt <= gate_cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (bus.rValid && bus.wReady) begin
            bus.rValid <= 1'b0;
            bus.rBusy  <= is_busy(ST_IDLE);
            state      <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          bus.rBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_rate_meter.sv
// Bench for edge_rate_meter: two instances (16-bit and 4-bit counts) share
// one stimulus so saturation and normal counting are seen side by side.
`timescale 1ns/1ps
module tb_edge_rate_meter;
  import edge_rate_meter_pkg::*;

  localparam int G = 100;

  typedef struct {
    string name;
    int    period;
    logic  level;
    int    cnt_a;
    logic  ovf_a;
    int    cnt_b;
    logic  ovf_b;
  } vec_t;

  typedef struct {
    string name;
    int    cnt_a;
    logic  ovf_a;
    int    cnt_b;
    logic  ovf_b;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  edge_rate_meter_if #(.CNT_W(16)) ifa();
  edge_rate_meter_if #(.CNT_W(4))  ifb();

  edge_rate_meter #(.GATE_CYCLES(G), .CNT_W(16), .SYNC_STAGES(2)) dut_a (
    .wClk (clk), .wRst (rst), .bus (ifa)
  );
  edge_rate_meter #(.GATE_CYCLES(G), .CNT_W(4), .SYNC_STAGES(2)) dut_b (
    .wClk (clk), .wRst (rst), .bus (ifb)
  );

  int   tests = 0;
  int   fails = 0;
  int   sig_period = 2;
  logic sig_level  = 1'b0;
  int   phase = 0;
  exp_t sb[$];
  vec_t vecs[8];

  // Input pattern source: period 0 means a static level.
  initial begin
    logic s;
    ifa.wSigIn = 1'b0;
    ifb.wSigIn = 1'b0;
    forever begin
      @(negedge clk);
      phase++;
      if (sig_period == 0) s = sig_level;
      else                 s = ((phase % sig_period) < (sig_period / 2));
      ifa.wSigIn = s;
      ifb.wSigIn = s;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got %0d tests", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_start(input logic v);
    ifa.wStart = v;
    ifb.wStart = v;
  endtask

  task automatic set_ready(input logic v);
    ifa.wReady = v;
    ifb.wReady = v;
  endtask

  task automatic run_meas(input string name, input int ca, input logic oa,
                          input int cb, input logic ob);
    exp_t e;
    int   n;
    e.name = name; e.cnt_a = ca; e.ovf_a = oa; e.cnt_b = cb; e.ovf_b = ob;
    sb.push_back(e);
    @(negedge clk);
    set_start(1'b1);
    @(posedge clk);
    #1;
    check({name, "_busy_arm"}, int'(ifa.rBusy), 1);
    @(negedge clk);
    set_start(1'b0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ifa.rValid && n < G + 20);
    check({name, "_latency"}, n, G + 1);
    check({name, "_valid_b"}, int'(ifb.rValid), 1);
    check({name, "_busy_hold"}, int'(ifa.rBusy), 0);
    e = sb.pop_front();
    check({e.name, "_cnt_a"}, int'(ifa.rCount), e.cnt_a);
    check({e.name, "_ovf_a"}, int'(ifa.rOverflow), int'(e.ovf_a));
    check({e.name, "_cnt_b"}, int'(ifb.rCount), e.cnt_b);
    check({e.name, "_ovf_b"}, int'(ifb.rOverflow), int'(e.ovf_b));
  endtask

  task automatic handshake(input string name);
    @(negedge clk);
    set_ready(1'b1);
    @(posedge clk);
    #1;
    check({name, "_valid_clr"}, int'(ifa.rValid | ifb.rValid), 0);
    @(negedge clk);
    set_ready(1'b0);
  endtask

  task automatic set_pattern(input int period, input logic level);
    @(negedge clk);
    sig_period = period;
    sig_level  = level;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    bit   ok;
    int   snap_ca, snap_cb;
    logic snap_oa, snap_ob;

    vecs[0] = '{"p2",     2, 1'b0, 50, 1'b0, 15, 1'b1};
    vecs[1] = '{"st_hi",  0, 1'b1,  0, 1'b0,  0, 1'b0};
    vecs[2] = '{"p10",   10, 1'b0, 10, 1'b0, 10, 1'b0};
    vecs[3] = '{"p4",     4, 1'b0, 25, 1'b0, 15, 1'b1};
    vecs[4] = '{"st_lo",  0, 1'b0,  0, 1'b0,  0, 1'b0};
    vecs[5] = '{"p5",     5, 1'b0, 20, 1'b0, 15, 1'b1};
    vecs[6] = '{"p20",   20, 1'b0,  5, 1'b0,  5, 1'b0};
    vecs[7] = '{"p50",   50, 1'b0,  2, 1'b0,  2, 1'b0};

    set_start(1'b0);
    set_ready(1'b0);
    rst = 1'b1;

    // Reset with the input toggling.
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_outs_a", int'({ifa.rBusy, ifa.rValid, ifa.rOverflow}), 0);
      check("rst_cnt_a", int'(ifa.rCount), 0);
      check("rst_outs_b", int'({ifb.rBusy, ifb.rValid, ifb.rOverflow, ifb.rCount}), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (ifa.rBusy || ifb.rBusy || ifa.rValid) ok = 1'b0;
    end
    check("idle_no_busy", int'(ok), 1);

    // Input held high through reset and the measurement.
    @(negedge clk);
    sig_period = 0;
    sig_level  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    run_meas("static_rst_hi", 0, 1'b0, 0, 1'b0);
    handshake("static_rst_hi");

    foreach (vecs[i]) begin
      set_pattern(vecs[i].period, vecs[i].level);
      run_meas(vecs[i].name, vecs[i].cnt_a, vecs[i].ovf_a, vecs[i].cnt_b, vecs[i].ovf_b);
      handshake(vecs[i].name);
    end

    // Backpressure with a wStart pulse during HOLD.
    set_pattern(2, 1'b0);
    run_meas("bp", 50, 1'b0, 15, 1'b1);
    snap_ca = int'(ifa.rCount);   snap_oa = ifa.rOverflow;
    snap_cb = int'(ifb.rCount);   snap_ob = ifb.rOverflow;
    ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      set_start(c == 5 || c == 6);
      @(posedge clk);
      #1;
      if (!ifa.rValid || !ifb.rValid || ifa.rBusy || ifb.rBusy) ok = 1'b0;
      if (int'(ifa.rCount) != snap_ca || ifa.rOverflow != snap_oa) ok = 1'b0;
      if (int'(ifb.rCount) != snap_cb || ifb.rOverflow != snap_ob) ok = 1'b0;
    end
    check("bp_stable", int'(ok), 1);
    check("bp_ovf_b_held", int'(ifb.rOverflow), 1);
    @(negedge clk);
    set_ready(1'b1);
    set_start(1'b1);
    @(posedge clk);
    #1;
    check("bp_valid_clr", int'(ifa.rValid), 0);
    check("bp_start_ignored", int'(ifa.rBusy | ifb.rBusy), 0);
    @(negedge clk);
    set_ready(1'b0);
    set_start(1'b0);
    @(posedge clk);
    #1;
    check("bp_back_idle", int'(ifa.rBusy), 0);

    // Reset 40 cycles into the gate window.
    set_pattern(10, 1'b0);
    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    repeat (41) @(negedge clk);
    check("mid_busy_pre", int'(ifa.rBusy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_busy", int'(ifa.rBusy | ifb.rBusy), 0);
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    repeat (150) begin
      @(posedge clk);
      #1;
      if (ifa.rValid || ifb.rValid || ifa.rBusy) ok = 1'b0;
    end
    check("mid_no_valid", int'(ok), 1);
    run_meas("after_rst", 10, 1'b0, 10, 1'b0);
    handshake("after_rst");

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
